// File: rtl/rob_retire_unit.sv
// In-order reorder buffer: rename allocates at the tail, writeback marks entries done,
// and up to two entries retire per cycle from the head, freeing their displaced pregs.
module rob_retire_unit #(
    parameter int DEPTH    = 16,
    parameter int PREG_W   = 6,
    parameter int NUM_PREG = 64,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                alloc_valid,
    input  logic                alloc_has_dest,
    input  logic [PREG_W-1:0]   alloc_dr_p,
    input  logic [PREG_W-1:0]   alloc_old_dr,
    output logic                alloc_ready,
    output logic [IDX_W-1:0]    alloc_rob_idx,
    input  logic                cmp0_valid,
    input  logic [IDX_W-1:0]    cmp0_idx,
    input  logic                cmp1_valid,
    input  logic [IDX_W-1:0]    cmp1_idx,
    output logic [NUM_PREG-1:0] retire_from_ROB,
    output logic [1:0]          retire_count,
    output logic [IDX_W:0]      rob_count,
    output logic                rob_empty
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0]       head_q, head_d;
    logic [CW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    done_q, done_d;
    logic [DEPTH-1:0]    has_dest_q, has_dest_d;
    logic [PREG_W-1:0]   dr_p_q [DEPTH];
    logic [PREG_W-1:0]   dr_p_d [DEPTH];
    logic [PREG_W-1:0]   old_dr_q [DEPTH];
    logic [PREG_W-1:0]   old_dr_d [DEPTH];
    logic [NUM_PREG-1:0] free_q, free_d;
    logic [1:0]          rcnt_q, rcnt_d;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] head1_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             alloc_fire;
    logic             ret0;
    logic             ret1;
    logic [1:0]       ret_n;

    assign head_idx   = head_q[IDX_W-1:0];
    assign head1_idx  = head_idx + IDX_W'(1);
    assign tail_idx   = tail_q[IDX_W-1:0];

    // No same-cycle bypass: a full ROB refuses allocation even while it retires.
    assign alloc_ready   = rstn & (count_q < CW'(DEPTH));
    assign alloc_fire    = alloc_valid & alloc_ready;
    assign alloc_rob_idx = tail_idx;

    assign ret0  = valid_q[head_idx] & done_q[head_idx];
    assign ret1  = ret0 & valid_q[head1_idx] & done_q[head1_idx];
    assign ret_n = {1'b0, ret0} + {1'b0, ret1};

    assign retire_from_ROB = free_q;
    assign retire_count    = rcnt_q;
    assign rob_count       = count_q;
    assign rob_empty       = (count_q == '0);

    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        has_dest_d = has_dest_q;
        dr_p_d     = dr_p_q;
        old_dr_d   = old_dr_q;
        free_d     = '0;

        // Completions to entries that are not live are dropped.
        if (cmp0_valid && valid_q[cmp0_idx]) begin
            done_d[cmp0_idx] = 1'b1;
        end
        if (cmp1_valid && valid_q[cmp1_idx]) begin
            done_d[cmp1_idx] = 1'b1;
        end

        if (ret0) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            if (has_dest_q[head_idx] && (old_dr_q[head_idx] != '0)) begin
                free_d[old_dr_q[head_idx]] = 1'b1;
            end
        end
        if (ret1) begin
            valid_d[head1_idx] = 1'b0;
            done_d[head1_idx]  = 1'b0;
            if (has_dest_q[head1_idx] && (old_dr_q[head1_idx] != '0)) begin
                free_d[old_dr_q[head1_idx]] = 1'b1;
            end
        end

        // The tail slot is never live when alloc_ready is high, so this cannot
        // collide with a completion or retirement of the same slot.
        if (alloc_fire) begin
            valid_d[tail_idx]    = 1'b1;
            done_d[tail_idx]     = 1'b0;
            has_dest_d[tail_idx] = alloc_has_dest;
            dr_p_d[tail_idx]     = alloc_dr_p;
            old_dr_d[tail_idx]   = alloc_old_dr;
        end

        tail_d  = tail_q + CW'(alloc_fire);
        head_d  = head_q + CW'(ret_n);
        count_d = count_q + CW'(alloc_fire) - CW'(ret_n);
        rcnt_d  = ret_n;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            done_q     <= '0;
            has_dest_q <= '0;
            free_q     <= '0;
            rcnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dr_p_q[i]   <= '0;
                old_dr_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            has_dest_q <= has_dest_d;
            free_q     <= free_d;
            rcnt_q     <= rcnt_d;
            dr_p_q     <= dr_p_d;
            old_dr_q   <= old_dr_d;
        end
    end

endmodule

// File: tb/tb_rob_retire_unit.sv
// Bench for rob_retire_unit: a hand-derived vector table, directed full/wrap and
// reset sequences, then random traffic checked against a queue-based ROB model.
module tb_rob_retire_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alloc_valid;
    logic        alloc_has_dest;
    logic [5:0]  alloc_dr_p;
    logic [5:0]  alloc_old_dr;
    logic        alloc_ready;
    logic [3:0]  alloc_rob_idx;
    logic        cmp0_valid;
    logic [3:0]  cmp0_idx;
    logic        cmp1_valid;
    logic [3:0]  cmp1_idx;
    logic [63:0] retire_from_ROB;
    logic [1:0]  retire_count;
    logic [4:0]  rob_count;
    logic        rob_empty;

    always #5 clk = ~clk;

    rob_retire_unit dut (
        .clk             (clk),
        .rstn            (rstn),
        .alloc_valid     (alloc_valid),
        .alloc_has_dest  (alloc_has_dest),
        .alloc_dr_p      (alloc_dr_p),
        .alloc_old_dr    (alloc_old_dr),
        .alloc_ready     (alloc_ready),
        .alloc_rob_idx   (alloc_rob_idx),
        .cmp0_valid      (cmp0_valid),
        .cmp0_idx        (cmp0_idx),
        .cmp1_valid      (cmp1_valid),
        .cmp1_idx        (cmp1_idx),
        .retire_from_ROB (retire_from_ROB),
        .retire_count    (retire_count),
        .rob_count       (rob_count),
        .rob_empty       (rob_empty)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the ROB as a program-ordered queue of live entries.
    typedef struct {
        int idx;
        bit hd;
        int old;
        bit done;
    } ent_t;

    ent_t        mq[$];
    int          m_tail  = 0;
    bit          m_known = 0;
    logic [63:0] e_free  = '0;
    int          e_rc    = 0;
    int          e_cnt   = 0;

    task automatic model_step();
        bit          acc;
        int          n;
        logic [63:0] f;
        ent_t        e;
        acc = rstn && alloc_valid && (mq.size() < 16);
        if (!rstn) begin
            mq.delete();
            m_tail  = 0;
            e_free  = '0;
            e_rc    = 0;
            e_cnt   = 0;
            m_known = 1;
            return;
        end
        if (!m_known) return;
        n = 0;
        f = '0;
        while (n < 2 && n < mq.size() && mq[n].done) begin
            if (mq[n].hd && mq[n].old != 0) f[mq[n].old] = 1'b1;
            n++;
        end
        repeat (n) void'(mq.pop_front());
        for (int k = 0; k < mq.size(); k++) begin
            if ((cmp0_valid && mq[k].idx == int'(cmp0_idx)) ||
                (cmp1_valid && mq[k].idx == int'(cmp1_idx))) begin
                e = mq[k];
                e.done = 1'b1;
                mq[k] = e;
            end
        end
        if (acc) begin
            e.idx  = m_tail % 16;
            e.hd   = alloc_has_dest;
            e.old  = int'(alloc_old_dr);
            e.done = 1'b0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 32;
        end
        e_free = f;
        e_rc   = n;
        e_cnt  = mq.size();
    endtask

    task automatic check_model();
        if (!m_known) return;
        check("m_alloc_ready", 64'(alloc_ready), 64'(rstn && (mq.size() < 16)));
        check("m_alloc_rob_idx", 64'(alloc_rob_idx), 64'(m_tail % 16));
        check("m_retire_from_ROB", retire_from_ROB, e_free);
        check("m_retire_count", 64'(retire_count), 64'(e_rc));
        check("m_rob_count", 64'(rob_count), 64'(e_cnt));
        check("m_rob_empty", 64'(rob_empty), 64'(e_cnt == 0));
    endtask

    task automatic drive(input logic r, input logic av, input logic hd,
                         input logic [5:0] dr, input logic [5:0] old,
                         input logic c0v, input logic [3:0] c0i,
                         input logic c1v, input logic [3:0] c1i);
        rstn           = r;
        alloc_valid    = av;
        alloc_has_dest = hd;
        alloc_dr_p     = dr;
        alloc_old_dr   = old;
        cmp0_valid     = c0v;
        cmp0_idx       = c0i;
        cmp1_valid     = c1v;
        cmp1_idx       = c1i;
        #1;
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic alloc(input logic hd, input logic [5:0] dr, input logic [5:0] old);
        drive(1'b1, 1'b1, hd, dr, old, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic step();
        check_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] pick();
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            return 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
        return 4'($urandom);
    endfunction

    // Expected values are what the outputs show while the row's inputs are applied.
    typedef struct {
        logic        av;
        logic        hd;
        logic [5:0]  dr;
        logic [5:0]  old;
        logic        c0v;
        logic [3:0]  c0i;
        logic        c1v;
        logic [3:0]  c1i;
        logic [3:0]  idx;
        logic [63:0] free;
        logic [1:0]  rc;
        logic [4:0]  cnt;
    } vec_t;

    function automatic vec_t mkv(input logic av, input logic hd, input logic [5:0] dr,
                                 input logic [5:0] old, input logic c0v, input logic [3:0] c0i,
                                 input logic c1v, input logic [3:0] c1i, input logic [3:0] idx,
                                 input logic [63:0] free, input logic [1:0] rc, input logic [4:0] cnt);
        vec_t v;
        v.av = av; v.hd = hd; v.dr = dr; v.old = old;
        v.c0v = c0v; v.c0i = c0i; v.c1v = c1v; v.c1i = c1i;
        v.idx = idx; v.free = free; v.rc = rc; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[26];

    initial begin
        // single entry: alloc, complete, retire, free pulse
        tbl[0]  = mkv(1'b1, 1'b1, 6'd33, 6'd5,  1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 64'h0,   2'd0, 5'd0);
        tbl[1]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 4'd0, 1'b0, 4'd0, 4'd1, 64'h0,   2'd0, 5'd1);
        tbl[2]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 64'h0,   2'd0, 5'd1);
        tbl[3]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 64'h20,  2'd1, 5'd0);
        tbl[4]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 64'h0,   2'd0, 5'd0);
        // out-of-order completion, in-order double retire
        tbl[5]  = mkv(1'b1, 1'b1, 6'd10, 6'd7,  1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 64'h0,   2'd0, 5'd0);
        tbl[6]  = mkv(1'b1, 1'b1, 6'd11, 6'd9,  1'b0, 4'd0, 1'b0, 4'd0, 4'd2, 64'h0,   2'd0, 5'd1);
        tbl[7]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b1, 4'd2, 4'd3, 64'h0,   2'd0, 5'd2);
        tbl[8]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 64'h0,   2'd0, 5'd2);
        tbl[9]  = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 4'd1, 1'b0, 4'd0, 4'd3, 64'h0,   2'd0, 5'd2);
        tbl[10] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 64'h0,   2'd0, 5'd2);
        tbl[11] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 64'h280, 2'd2, 5'd0);
        tbl[12] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 64'h0,   2'd0, 5'd0);
        // no-dest and old_dr=0 retire without freeing
        tbl[13] = mkv(1'b1, 1'b0, 6'd0,  6'd12, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 64'h0,   2'd0, 5'd0);
        tbl[14] = mkv(1'b1, 1'b1, 6'd20, 6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 64'h0,   2'd0, 5'd1);
        tbl[15] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 4'd3, 1'b1, 4'd4, 4'd5, 64'h0,   2'd0, 5'd2);
        tbl[16] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 64'h0,   2'd0, 5'd2);
        tbl[17] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 64'h0,   2'd2, 5'd0);
        tbl[18] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 64'h0,   2'd0, 5'd0);
        // alloc and retire on the same edge with one entry live
        tbl[19] = mkv(1'b1, 1'b1, 6'd21, 6'd3,  1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 64'h0,   2'd0, 5'd0);
        tbl[20] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b1, 4'd5, 1'b0, 4'd0, 4'd6, 64'h0,   2'd0, 5'd1);
        tbl[21] = mkv(1'b1, 1'b1, 6'd22, 6'd4,  1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 64'h0,   2'd0, 5'd1);
        tbl[22] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 64'h8,   2'd1, 5'd1);
        tbl[23] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b1, 4'd6, 4'd7, 64'h0,   2'd0, 5'd1);
        tbl[24] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 64'h0,   2'd0, 5'd1);
        tbl[25] = mkv(1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 64'h10,  2'd1, 5'd0);

        // reset held two cycles
        idle(1'b0);
        check("t1_ready_in_reset", 64'(alloc_ready), 64'd0);
        step();
        idle(1'b0);
        check("t1_ready_in_reset2", 64'(alloc_ready), 64'd0);
        check("t1_empty", 64'(rob_empty), 64'd1);
        check("t1_idx", 64'(alloc_rob_idx), 64'd0);
        check("t1_free", retire_from_ROB, 64'd0);
        step();
        idle(1'b1);
        check("t1_ready_after", 64'(alloc_ready), 64'd1);
        step();

        for (int i = 0; i < 26; i++) begin
            drive(1'b1, tbl[i].av, tbl[i].hd, tbl[i].dr, tbl[i].old,
                  tbl[i].c0v, tbl[i].c0i, tbl[i].c1v, tbl[i].c1i);
            check($sformatf("row%0d_ready", i), 64'(alloc_ready), 64'd1);
            check($sformatf("row%0d_idx", i), 64'(alloc_rob_idx), 64'(tbl[i].idx));
            check($sformatf("row%0d_free", i), retire_from_ROB, tbl[i].free);
            check($sformatf("row%0d_rcnt", i), 64'(retire_count), 64'(tbl[i].rc));
            check($sformatf("row%0d_count", i), 64'(rob_count), 64'(tbl[i].cnt));
            step();
        end

        // fill to full, refused alloc, retire one, wrap into idx0
        idle(1'b0); step();
        idle(1'b0); step();
        for (int i = 0; i < 16; i++) begin
            alloc(1'b1, 6'(i + 20), 6'(i + 1));
            step();
        end
        alloc(1'b1, 6'd40, 6'd50);
        check("t4_full_ready", 64'(alloc_ready), 64'd0);
        check("t4_full_count", 64'(rob_count), 64'd16);
        step();
        drive(1'b1, 1'b1, 1'b1, 6'd41, 6'd51, 1'b1, 4'd0, 1'b0, 4'd0);
        check("t4_ignored_count", 64'(rob_count), 64'd16);
        step();
        alloc(1'b1, 6'd42, 6'd52);
        check("t4_no_bypass_ready", 64'(alloc_ready), 64'd0);
        step();
        alloc(1'b1, 6'd43, 6'd53);
        check("t4_after_retire_ready", 64'(alloc_ready), 64'd1);
        check("t4_after_retire_idx", 64'(alloc_rob_idx), 64'd0);
        check("t4_after_retire_free", retire_from_ROB, 64'h2);
        check("t4_after_retire_count", 64'(rob_count), 64'd15);
        step();
        idle(1'b1);
        check("t4_wrap_count", 64'(rob_count), 64'd16);
        check("t4_wrap_idx", 64'(alloc_rob_idx), 64'd1);
        check("t4_wrap_ready", 64'(alloc_ready), 64'd0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 4'(i + 1), 1'b1, 4'(i + 9));
            step();
        end

        // stray completion while empty, then reset with entries in flight
        idle(1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 4'd5, 1'b1, 4'd0);
        step();
        alloc(1'b1, 6'd1, 6'd11); step();
        alloc(1'b1, 6'd2, 6'd12); step();
        alloc(1'b1, 6'd3, 6'd13); step();
        idle(1'b1); step();
        idle(1'b1);
        check("t6_stray_no_retire", 64'(retire_count), 64'd0);
        check("t6_inflight_count", 64'(rob_count), 64'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 4'd0, 1'b1, 4'd1);
        step();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 4'd2, 1'b0, 4'd0);
        check("t6_reset_count", 64'(rob_count), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check($sformatf("t6_no_free_%0d", i), retire_from_ROB, 64'd0);
            step();
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] i0;
            logic [3:0] i1;
            i0 = pick();
            i1 = ($urandom_range(0, 5) == 0) ? i0 : pick();
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 4) != 0),
                  6'($urandom),
                  ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom),
                  ($urandom_range(0, 2) == 0), i0,
                  ($urandom_range(0, 2) == 0), i1);
            step();
        end
        idle(1'b1);
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
